// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: two-stage valid/ready vector ALU with lane masking, saturation, overflow flags and sum reduction
module vec_alu_pipe #(
    parameter int LANES = 8,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            funct,
    input  logic                  sat_en,
    input  logic [LANES-1:0]      lane_mask,
    input  logic [LANES*DW-1:0]   vec_a,
    input  logic [LANES*DW-1:0]   vec_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_vec,
    output logic [LANES-1:0]      out_ovf,
    output logic                  out_err
);
    localparam int AW = DW + $clog2(LANES);
    localparam logic [5:0] F_ADD  = 6'b110000;
    localparam logic [5:0] F_SUB  = 6'b110001;
    localparam logic [5:0] F_AND  = 6'b110010;
    localparam logic [5:0] F_OR   = 6'b110011;
    localparam logic [5:0] F_XOR  = 6'b110100;
    localparam logic [5:0] F_MUL  = 6'b110101;
    localparam logic [5:0] F_RSUM = 6'b110110;
    localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};

    logic                s1_valid;
    logic [5:0]          s1_funct;
    logic                s1_sat;
    logic [LANES-1:0]    s1_mask;
    logic [LANES*DW-1:0] s1_a;
    logic [LANES*DW-1:0] s1_b;
    logic [LANES*DW-1:0] res_vec;
    logic [LANES-1:0]    res_ovf;
    logic                res_err;
    logic                adv1;
    logic                adv2;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    // S1: capture the operand beat whenever the stage can advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_funct <= '0;
            s1_sat   <= 1'b0;
            s1_mask  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_funct <= funct;
                s1_sat   <= sat_en;
                s1_mask  <= lane_mask;
                s1_a     <= vec_a;
                s1_b     <= vec_b;
            end
        end
    end

    // S2 datapath: per-lane ops with overflow detection, then the optional lane-0 reduction
    always_comb begin
        logic signed [DW-1:0]   a;
        logic signed [DW-1:0]   b;
        logic [DW:0]            add;
        logic [DW:0]            sub;
        logic signed [2*DW-1:0] prod;
        logic [DW-1:0]          r;
        logic                   o;
        logic                   acc_ovf;
        logic [AW-1:0]          acc;
        res_vec = '0;
        res_ovf = '0;
        res_err = !(s1_funct inside {[F_ADD:F_RSUM]});
        acc     = '0;
        for (int i = 0; i < LANES; i++) begin
            a    = s1_a[i*DW +: DW];
            b    = s1_b[i*DW +: DW];
            add  = {a[DW-1], a} + {b[DW-1], b};
            sub  = {a[DW-1], a} - {b[DW-1], b};
            prod = a * b;
            r    = '0;
            o    = 1'b0;
            case (s1_funct)
                F_ADD: begin
                    o = add[DW] ^ add[DW-1];
                    r = (o && s1_sat) ? (add[DW] ? MINV : MAXV) : add[DW-1:0];
                end
                F_SUB: begin
                    o = sub[DW] ^ sub[DW-1];
                    r = (o && s1_sat) ? (sub[DW] ? MINV : MAXV) : sub[DW-1:0];
                end
                F_MUL: begin
                    o = !((&prod[2*DW-1:DW-1]) || !(|prod[2*DW-1:DW-1]));
                    r = (o && s1_sat) ? (prod[2*DW-1] ? MINV : MAXV) : prod[DW-1:0];
                end
                F_AND: r = a & b;
                F_OR:  r = a | b;
                F_XOR: r = a ^ b;
                default: ;
            endcase
            if (s1_mask[i]) begin
                res_vec[i*DW +: DW] = r;
                res_ovf[i]          = o;
                acc                 = acc + AW'(a);
            end
        end
        acc_ovf = !((&acc[AW-1:DW-1]) || !(|acc[AW-1:DW-1]));
        if (s1_funct == F_RSUM) begin
            res_ovf[0]       = acc_ovf;
            res_vec[DW-1:0]  = (acc_ovf && s1_sat) ? (acc[AW-1] ? MINV : MAXV) : acc[DW-1:0];
        end
    end

    // S2 register: results only move when the consumer side can advance, so a stall holds them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_ovf   <= '0;
            out_err   <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_vec <= res_vec;
                out_ovf <= res_ovf;
                out_err <= res_err;
            end
        end
    end
endmodule
